// File: rtl/seq_pkg.sv
// Shared types and constants for the RV32 multi-cycle instruction sequencer and its control unit.
package seq_pkg;

   typedef logic [2:0] seq_state_t;

   localparam seq_state_t StIdle      = 3'd0;
   localparam seq_state_t StFetch     = 3'd1;
   localparam seq_state_t StDecode    = 3'd2;
   localparam seq_state_t StExecute   = 3'd3;
   localparam seq_state_t StWriteback = 3'd4;
   localparam seq_state_t StHalted    = 3'd5;
   localparam seq_state_t StTrap      = 3'd6;

   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_I_TYPE = 7'b0010011;

   typedef enum logic [1:0] {
      CauseNone     = 2'b00,
      CauseIllegal  = 2'b01,
      CauseTimeout  = 2'b10,
      CauseMisalign = 2'b11
   } trap_cause_t;

   function automatic logic is_supported(input logic [6:0] op);
      return (op == OP_R_TYPE) || (op == OP_I_TYPE);
   endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Fetch timeout counter: cleared outside FETCH, counts cycles without imem_ready.
module fetch_watchdog #(
   parameter int unsigned FETCH_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LastCount = 8'(FETCH_TIMEOUT - 1);

   logic [7:0] count_q, count_d;

   // Saturates at the last count; the sequencer leaves FETCH on that cycle anyway.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != LastCount)) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == LastCount);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with sticky trap and halt support.
// Optional retirement counter enabled by defining INSTR_SEQ_RETIRE_CNT_EN.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned FETCH_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   input  logic        ctl_register_write,
   output logic        alu_en,
   output logic        rf_we,
   output logic [31:0] pc,
   input  logic        halt_req,
   output logic        halted,
   output logic        trap,
   output logic [1:0]  trap_cause
`ifdef INSTR_SEQ_RETIRE_CNT_EN
   ,
   output logic [31:0] retire_cnt
`endif
);

   seq_state_t  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   trap_cause_t cause_q, cause_d;
   logic        rf_we_q, rf_we_d;
   logic        wd_clr, wd_en, wd_expired;

   assign wd_clr = (state_q != StFetch);
   assign wd_en  = (state_q == StFetch) && !imem_ready;

   fetch_watchdog #(
      .FETCH_TIMEOUT(FETCH_TIMEOUT)
   ) u_fetch_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (wd_clr),
      .en     (wd_en),
      .expired(wd_expired)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cause_d = cause_q;
      rf_we_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (RESET_PC[1:0] != 2'b00) begin
               state_d = StTrap;
               cause_d = CauseMisalign;
            end else if (halt_req) begin
               state_d = StHalted;
            end else begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            // A ready response takes priority over an expiring timeout.
            if (imem_ready) begin
               instr_d = imem_rdata;
               state_d = StDecode;
            end else if (wd_expired) begin
               state_d = StTrap;
               cause_d = CauseTimeout;
            end
         end
         StDecode: begin
            if (!is_supported(instr_q[6:0])) begin
               state_d = StTrap;
               cause_d = CauseIllegal;
            end else begin
               state_d = StExecute;
            end
         end
         StExecute: begin
            // Registered so the strobe in WRITEBACK has no input-to-output path.
            rf_we_d = ctl_register_write && (instr_q[11:7] != 5'd0);
            state_d = StWriteback;
         end
         StWriteback: begin
            pc_d    = pc_q + 32'd4;
            state_d = halt_req ? StHalted : StFetch;
         end
         StHalted: begin
            if (!halt_req) begin
               state_d = StFetch;
            end
         end
         StTrap: begin
            state_d = StTrap;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         cause_q <= CauseNone;
         rf_we_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cause_q <= cause_d;
         rf_we_q <= rf_we_d;
      end
   end

   assign imem_req   = (state_q == StFetch);
   assign imem_addr  = pc_q;
   assign alu_en     = (state_q == StExecute);
   assign rf_we      = rf_we_q;
   assign pc         = pc_q;
   assign halted     = (state_q == StHalted);
   assign trap       = (state_q == StTrap);
   assign trap_cause = cause_q;

   assign opcode = instr_q[6:0];
   assign rd     = instr_q[11:7];
   assign funct3 = instr_q[14:12];
   assign rs1    = instr_q[19:15];
   assign rs2    = instr_q[24:20];
   assign funct7 = instr_q[31:25];

`ifdef INSTR_SEQ_RETIRE_CNT_EN
   logic [31:0] retire_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_q <= '0;
      end else if (state_q == StWriteback) begin
         retire_q <= retire_q + 32'd1;
      end
   end

   assign retire_cnt = retire_q;
`else
   // Retirement counter not built.
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer against a transaction-level PC/trap model.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        ctl_register_write;
   logic        halt_req;

   logic        imem_req, alu_en, rf_we, halted, trap;
   logic [31:0] imem_addr, pc;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;
   logic [1:0]  trap_cause;

   logic        d2_imem_req, d2_alu_en, d2_rf_we, d2_halted, d2_trap;
   logic [31:0] d2_imem_addr, d2_pc;
   logic [6:0]  d2_opcode, d2_funct7;
   logic [2:0]  d2_funct3;
   logic [4:0]  d2_rs1, d2_rs2, d2_rd;
   logic [1:0]  d2_trap_cause;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
   logic [31:0] retire_cnt, d2_retire_cnt;
`endif

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] m_pc;
   int          m_retired;

   always #5 clk = ~clk;

   instr_sequencer dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ready        (imem_ready),
      .imem_rdata        (imem_rdata),
      .opcode            (opcode),
      .funct3            (funct3),
      .funct7            (funct7),
      .rs1               (rs1),
      .rs2               (rs2),
      .rd                (rd),
      .ctl_register_write(ctl_register_write),
      .alu_en            (alu_en),
      .rf_we             (rf_we),
      .pc                (pc),
      .halt_req          (halt_req),
      .halted            (halted),
      .trap              (trap),
      .trap_cause        (trap_cause)
`ifdef INSTR_SEQ_RETIRE_CNT_EN
      ,
      .retire_cnt        (retire_cnt)
`endif
   );

   instr_sequencer #(
      .RESET_PC     (32'h0000_0102),
      .FETCH_TIMEOUT(3)
   ) dut_misaligned (
      .clk               (clk),
      .rst_n             (rst_n),
      .imem_req          (d2_imem_req),
      .imem_addr         (d2_imem_addr),
      .imem_ready        (imem_ready),
      .imem_rdata        (imem_rdata),
      .opcode            (d2_opcode),
      .funct3            (d2_funct3),
      .funct7            (d2_funct7),
      .rs1               (d2_rs1),
      .rs2               (d2_rs2),
      .rd                (d2_rd),
      .ctl_register_write(ctl_register_write),
      .alu_en            (d2_alu_en),
      .rf_we             (d2_rf_we),
      .pc                (d2_pc),
      .halt_req          (halt_req),
      .halted            (d2_halted),
      .trap              (d2_trap),
      .trap_cause        (d2_trap_cause)
`ifdef INSTR_SEQ_RETIRE_CNT_EN
      ,
      .retire_cnt        (d2_retire_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in IDLE, one sample point after reset release.
   task automatic apply_reset();
      rst_n = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = '0;
      halt_req = 1'b0;
      ctl_register_write = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      m_pc = 32'h0;
      m_retired = 0;
   endtask

   task automatic start();
      apply_reset();
      tick();
   endtask

   // One instruction from FETCH; waits = cycles without ready before the ready cycle.
   task automatic do_instr(input logic [31:0] word, input int waits, input logic ctl,
                           input logic halt_at_exec);
      logic legal, exp_we;
      legal  = (word[6:0] == 7'b0110011) || (word[6:0] == 7'b0010011);
      exp_we = ctl && (word[11:7] != 5'd0);
      ctl_register_write = ctl;
      for (int i = 0; i < waits; i++) begin
         halt_req = 1'($urandom_range(0, 1));
         imem_ready = 1'b0;
         imem_rdata = $urandom;
         n_chk++;
         if (imem_req !== 1'b1 || imem_addr !== m_pc || trap !== 1'b0)
            $display("FAIL fetch_wait: req=%b addr=%h trap=%b, want req=1 addr=%h trap=0",
                     imem_req, imem_addr, trap, m_pc);
         else n_pass++;
         tick();
      end
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc)
         $display("FAIL fetch_ready: req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, m_pc);
      else n_pass++;
      imem_ready = 1'b1;
      imem_rdata = word;
      tick();
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      n_chk++;
      if ({funct7, rs2, rs1, funct3, rd, opcode} !== word || imem_req !== 1'b0 ||
          alu_en !== 1'b0 || rf_we !== 1'b0)
         $display("FAIL decode: fields=%h req=%b alu=%b we=%b, want fields=%h req=0 alu=0 we=0",
                  {funct7, rs2, rs1, funct3, rd, opcode}, imem_req, alu_en, rf_we, word);
      else n_pass++;
      tick();
      if (!legal) begin
         n_chk++;
         if (trap !== 1'b1 || trap_cause !== 2'b01 || pc !== m_pc || rf_we !== 1'b0 ||
             alu_en !== 1'b0)
            $display("FAIL illegal_trap: trap=%b cause=%b pc=%h we=%b alu=%b, want 1 01 %h 0 0",
                     trap, trap_cause, pc, rf_we, alu_en, m_pc);
         else n_pass++;
         halt_req = 1'b0;
         return;
      end
      n_chk++;
      if (alu_en !== 1'b1 || rf_we !== 1'b0 || trap !== 1'b0)
         $display("FAIL execute: alu=%b we=%b trap=%b, want 1 0 0", alu_en, rf_we, trap);
      else n_pass++;
      halt_req = halt_at_exec;
      tick();
      n_chk++;
      if (rf_we !== exp_we || alu_en !== 1'b0 || pc !== m_pc)
         $display("FAIL writeback: we=%b alu=%b pc=%h, want we=%b alu=0 pc=%h",
                  rf_we, alu_en, pc, exp_we, m_pc);
      else n_pass++;
      m_pc = m_pc + 32'd4;
      m_retired++;
      tick();
      n_chk++;
      if (halt_at_exec) begin
         if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== m_pc || rf_we !== 1'b0)
            $display("FAIL halt_entry: halted=%b req=%b pc=%h we=%b, want 1 0 %h 0",
                     halted, imem_req, pc, rf_we, m_pc);
         else n_pass++;
      end else begin
         if (imem_req !== 1'b1 || imem_addr !== m_pc || pc !== m_pc || rf_we !== 1'b0)
            $display("FAIL next_fetch: req=%b addr=%h pc=%h we=%b, want 1 %h %h 0",
                     imem_req, imem_addr, pc, rf_we, m_pc, m_pc);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_chk++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0 || alu_en !== 1'b0 ||
          rf_we !== 1'b0 || halted !== 1'b0 || trap !== 1'b0 || trap_cause !== 2'b00 ||
          {funct7, rs2, rs1, funct3, rd, opcode} !== 32'h0)
         $display("FAIL reset_values: req=%b addr=%h pc=%h alu=%b we=%b halted=%b trap=%b cause=%b",
                  imem_req, imem_addr, pc, alu_en, rf_we, halted, trap, trap_cause);
      else n_pass++;
      tick();
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0)
         $display("FAIL first_fetch: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
      else n_pass++;
      n_chk++;
      if (d2_trap !== 1'b1 || d2_trap_cause !== 2'b11 || d2_pc !== 32'h102 || d2_imem_req !== 1'b0)
         $display("FAIL misaligned_reset_pc: trap=%b cause=%b pc=%h req=%b, want 1 11 00000102 0",
                  d2_trap, d2_trap_cause, d2_pc, d2_imem_req);
      else n_pass++;
   endtask

   task automatic test_add_x0();
      do_instr(32'h0020_8033, 0, 1'b1, 1'b0);
      n_chk++;
      if (pc !== 32'd4)
         $display("FAIL add_x0_pc: pc=%h want 00000004", pc);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      start();
      repeat (3) do_instr(32'h0020_81B3, 1, 1'b1, 1'b0);
      n_chk++;
      if (pc !== 32'd12)
         $display("FAIL stream_pc: pc=%h want 0000000c", pc);
      else n_pass++;
   endtask

   task automatic test_illegal();
      start();
      do_instr(32'h0000_0003, 2, 1'b1, 1'b0);
      repeat (3) begin
         imem_ready = 1'($urandom_range(0, 1));
         halt_req = 1'($urandom_range(0, 1));
         tick();
      end
      n_chk++;
      if (trap !== 1'b1 || trap_cause !== 2'b01 || pc !== 32'h0 || rf_we !== 1'b0 ||
          imem_req !== 1'b0 || halted !== 1'b0)
         $display("FAIL trap_sticky: trap=%b cause=%b pc=%h we=%b req=%b halted=%b",
                  trap, trap_cause, pc, rf_we, imem_req, halted);
      else n_pass++;
   endtask

   task automatic test_timeout();
      start();
      imem_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         n_chk++;
         if (imem_req !== 1'b1 || trap !== 1'b0)
            $display("FAIL timeout_wait%0d: req=%b trap=%b, want 1 0", i, imem_req, trap);
         else n_pass++;
         tick();
      end
      n_chk++;
      if (trap !== 1'b1 || trap_cause !== 2'b10 || imem_req !== 1'b0 || pc !== 32'h0)
         $display("FAIL timeout_trap: trap=%b cause=%b req=%b pc=%h, want 1 10 0 0",
                  trap, trap_cause, imem_req, pc);
      else n_pass++;
      start();
      do_instr(32'h0011_0093, 14, 1'b1, 1'b0);
      n_chk++;
      if (trap !== 1'b0 || pc !== 32'd4)
         $display("FAIL ready_on_last_cycle: trap=%b pc=%h, want 0 00000004", trap, pc);
      else n_pass++;
   endtask

   task automatic test_halt();
      start();
      do_instr(32'h0020_81B3, 0, 1'b1, 1'b1);
      repeat (3) begin
         tick();
         n_chk++;
         if (halted !== 1'b1 || pc !== 32'd4 || imem_req !== 1'b0 || alu_en !== 1'b0)
            $display("FAIL halted_hold: halted=%b pc=%h req=%b alu=%b", halted, pc, imem_req, alu_en);
         else n_pass++;
      end
      halt_req = 1'b0;
      tick();
      n_chk++;
      if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd4)
         $display("FAIL resume: halted=%b req=%b addr=%h, want 0 1 00000004",
                  halted, imem_req, imem_addr);
      else n_pass++;
      do_instr(32'h0020_81B3, 0, 1'b0, 1'b0);
      // Halt requested at the IDLE boundary.
      rst_n = 1'b0;
      halt_req = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      n_chk++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0)
         $display("FAIL idle_halt: halted=%b req=%b pc=%h, want 1 0 0", halted, imem_req, pc);
      else n_pass++;
      halt_req = 1'b0;
   endtask

   task automatic test_reset_mid_exec();
      start();
      ctl_register_write = 1'b1;
      imem_ready = 1'b1;
      imem_rdata = 32'h0020_81B3;
      tick();
      imem_ready = 1'b0;
      tick();
      n_chk++;
      if (alu_en !== 1'b1)
         $display("FAIL pre_reset_exec: alu=%b want 1", alu_en);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (pc !== 32'h0 || imem_addr !== 32'h0 || alu_en !== 1'b0 || rf_we !== 1'b0 ||
          imem_req !== 1'b0 || trap !== 1'b0 || {funct7, rs2, rs1, funct3, rd, opcode} !== 32'h0)
         $display("FAIL async_reset: pc=%h addr=%h alu=%b we=%b req=%b trap=%b instr=%h",
                  pc, imem_addr, alu_en, rf_we, imem_req, trap,
                  {funct7, rs2, rs1, funct3, rd, opcode});
      else n_pass++;
      repeat (2) begin
         tick();
         n_chk++;
         if (rf_we !== 1'b0)
            $display("FAIL no_we_in_reset: we=%b want 0", rf_we);
         else n_pass++;
      end
      rst_n = 1'b1;
      m_pc = 32'h0;
      tick();
      n_chk++;
      if (rf_we !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
         $display("FAIL after_reset_fetch: we=%b req=%b addr=%h, want 0 1 0", rf_we, imem_req, imem_addr);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] w;
      logic        h;
      start();
      for (int n = 0; n < 25; n++) begin
         w = $urandom;
         w[6:0] = ($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011;
         h = ($urandom_range(0, 4) == 0);
         do_instr(w, int'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), h);
         if (h) begin
            halt_req = 1'b0;
            tick();
            n_chk++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc)
               $display("FAIL rand_resume: req=%b addr=%h, want 1 %h", imem_req, imem_addr, m_pc);
            else n_pass++;
         end
      end
`ifdef INSTR_SEQ_RETIRE_CNT_EN
      n_chk++;
      if (retire_cnt !== 32'(m_retired))
         $display("FAIL retire_cnt: got %0d want %0d", retire_cnt, m_retired);
      else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_add_x0();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_halt();
      test_reset_mid_exec();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the RV32 core. It fetches one instruction at a time from instruction memory over a request/ready handshake, then presents the opcode, funct3 and funct7 fields to the combinational control unit. It then steps through decode, execute and writeback, gating the ALU enable and register-file write strobe. It owns the PC and raises a sticky trap on unsupported opcodes or fetch timeout.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `FETCH_TIMEOUT`, default 15: maximum cycles in FETCH without `imem_ready` before trapping (range 1..255).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: fetch request; high throughout FETCH.
- `imem_addr` out 32: fetch address, equal to `pc` while `imem_req` is high.
- `imem_ready` in 1: `imem_rdata` valid this cycle; only meaningful while `imem_req` is high.
- `imem_rdata` in 32: instruction word.
- `opcode` out 7, `funct3` out 3, `funct7` out 7: fields of the latched instruction, wired to the control unit.
- `rs1`, `rs2`, `rd` out 5 each: register indices from the latched instruction.
- `ctl_register_write` in 1: write-enable decision from the control unit.
- `alu_en` out 1: high only in EXECUTE.
- `rf_we` out 1: one-cycle strobe in WRITEBACK.
- `pc` out 32: current PC.
- `halt_req` in 1: request to stop at the next instruction boundary.
- `halted` out 1: high in HALTED.
- `trap` out 1: sticky until reset.
- `trap_cause` out 2: 00 none, 01 illegal opcode, 10 fetch timeout, 11 misaligned `RESET_PC`.

## Operation
- States are IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED, TRAP.
- IDLE (entered on reset, lasts 1 cycle):
  - `RESET_PC[1:0]` != 0 → TRAP, cause 11.
  - Otherwise, `halt_req` high → HALTED; else → FETCH.
- FETCH:
  - `imem_req`=1. When `imem_ready`=1, latch `imem_rdata` into the instruction register → DECODE.
  - The timeout counter clears on FETCH entry and increments each cycle without ready. When the count reaches `FETCH_TIMEOUT` → TRAP, cause 10.
  - Ready arriving in the same cycle the count would expire wins.
- DECODE (1 cycle): if opcode is neither 7'b0110011 (R-type) nor 7'b0010011 (I-type) → TRAP, cause 01; else → EXECUTE.
- EXECUTE (1 cycle): `alu_en`=1 → WRITEBACK.
- WRITEBACK (1 cycle):
  - `rf_we` = `ctl_register_write` && (`rd` != 0).
  - `pc` <= `pc` + 4, wrapping modulo 2^32.
  - `halt_req` high → HALTED; else → FETCH.
- HALTED: all strobes low. `halt_req` low → FETCH at the current `pc`.
- TRAP: absorbing state. All strobes low, `pc` frozen; only `rst_n` exits.
- `halt_req` is ignored in FETCH, DECODE and EXECUTE. An instruction in flight always completes or traps.

## Timing
- Reset values: `pc`=`RESET_PC`; instruction register 0 (so `opcode`/`funct3`/`funct7`/`rs1`/`rs2`/`rd` are 0); `imem_req`, `alu_en`, `rf_we`, `halted`, `trap`=0; `trap_cause`=00; `imem_addr`=`RESET_PC`.
- Minimum instruction latency is 4 cycles (FETCH with immediate ready, DECODE, EXECUTE, WRITEBACK), so peak throughput is 1 instruction per 4 cycles.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Reset asserted mid-instruction aborts immediately: no `rf_we` is issued and the PC returns to `RESET_PC`.
- `trap` and `trap_cause` update on the edge entering TRAP.

## Configuration
- `INSTR_SEQ_RETIRE_CNT_EN` defined:
  - Adds output `retire_cnt` (out 32), reset to 0.
  - Increments once per WRITEBACK cycle and wraps at 2^32.
  - Frozen in HALTED and TRAP.
- Undefined: the port and the counter are absent.

## Structure
- Shared package `seq_pkg` holds:
  - state enum `seq_state_t`;
  - opcode constants `OP_R_TYPE` and `OP_I_TYPE`, shared with the control unit;
  - trap-cause enum `trap_cause_t`.
- One natural sub-module is `fetch_watchdog`, containing the timeout counter with clear, enable and `expired` outputs.

## Test plan
- Reset release, `imem_ready` tied high, memory returns 0x00208033 (add x0,x1,x2) → `imem_addr`=0 in cycle 1 after IDLE. `rf_we` stays 0 because rd=0, and `pc`=4 after 4 cycles.
- Stream of 3 instructions (add x3,x1,x2 = 0x002081B3), ready on 2nd request cycle → `rf_we` pulses once per instruction and `pc` reaches 12 after 15 cycles.
- Word 0x00000003 (load opcode) → TRAP, `trap_cause`=01, `pc` frozen at its fetch address, no `rf_we`.
- `imem_ready` held low with `FETCH_TIMEOUT`=15 → TRAP with cause 10 exactly 15 cycles after FETCH entry. A ready on the 15th cycle instead proceeds to DECODE.
- `halt_req` raised during EXECUTE → WRITEBACK completes, then HALTED. Dropping `halt_req` refetches at `pc`+4.
- `rst_n` pulsed low during EXECUTE → outputs return to reset values asynchronously and no `rf_we` pulse occurs.
